// File: rtl/gpio_expander_regs_if.sv
// Register-bus link between the i2cSlave core (master) and the GPIO expander
// register file (slave): byte pointer, write data, strobes and read-back data.
interface gpio_expander_regs_if;
    logic [7:0] addr;
    logic [7:0] dataIn;
    logic       writeEn;
    logic       readEn;
    logic [7:0] dataOut;

    modport master (
        output addr,
        output dataIn,
        output writeEn,
        output readEn,
        input  dataOut
    );

    modport slave (
        input  addr,
        input  dataIn,
        input  writeEn,
        input  readEn,
        output dataOut
    );
endinterface

// File: rtl/gpio_expander_regs.sv
// TCA9539-style register file and pin logic for NUM_PORTS 8-bit GPIO ports:
// input sync, polarity, direction and a snapshot-based open-drain interrupt.
module gpio_expander_regs #(
    parameter int         NUM_PORTS   = 2,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] OUT_RESET   = 8'hFF,
    parameter logic [7:0] POL_RESET   = 8'h00,
    parameter logic [7:0] CFG_RESET   = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    gpio_expander_regs_if.slave    bus,
    input  logic [8*NUM_PORTS-1:0] gpioIn,
    output logic [8*NUM_PORTS-1:0] gpioOut,
    output logic [8*NUM_PORTS-1:0] gpioOe,
    output logic                   intN
);

    localparam int W  = 8 * NUM_PORTS;
    localparam int CW = $clog2(SYNC_STAGES + 1);

    logic [W-1:0]         outReg;
    logic [W-1:0]         polReg;
    logic [W-1:0]         cfgReg;
    logic [W-1:0]         snap;
    logic [W-1:0]         syncPipe [SYNC_STAGES];
    logic [W-1:0]         syncVal;
    logic [CW-1:0]        primeCnt;
    logic [7:0]           dataOutReg;
    logic [7:0]           rdData;
    logic [NUM_PORTS-1:0] wrOut;
    logic [NUM_PORTS-1:0] wrPol;
    logic [NUM_PORTS-1:0] wrCfg;
    logic [NUM_PORTS-1:0] rdIn;

    assign syncVal     = syncPipe[SYNC_STAGES-1];
    assign gpioOut     = outReg;
    assign gpioOe      = ~cfgReg;
    assign bus.dataOut = dataOutReg;

    // Address decode and read mux share one pass over the ports.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wrOut  = '0;
        wrPol  = '0;
        wrCfg  = '0;
        rdIn   = '0;
        rdData = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.addr == 8'(p)) begin
                rdIn[p] = bus.readEn;
                rdData  = syncVal[8*p +: 8] ^ polReg[8*p +: 8];
            end
            if (bus.addr == 8'(NUM_PORTS + p)) begin
                wrOut[p] = bus.writeEn;
                rdData   = outReg[8*p +: 8];
            end
            if (bus.addr == 8'(2*NUM_PORTS + p)) begin
                wrPol[p] = bus.writeEn;
                rdData   = polReg[8*p +: 8];
            end
            if (bus.addr == 8'(3*NUM_PORTS + p)) begin
                wrCfg[p] = bus.writeEn;
                rdData   = cfgReg[8*p +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            outReg <= {NUM_PORTS{OUT_RESET}};
            polReg <= {NUM_PORTS{POL_RESET}};
            cfgReg <= {NUM_PORTS{CFG_RESET}};
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wrOut[p]) outReg[8*p +: 8] <= bus.dataIn;
                if (wrPol[p]) polReg[8*p +: 8] <= bus.dataIn;
                if (wrCfg[p]) cfgReg[8*p +: 8] <= bus.dataIn;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is a handful of flops that must start at zero, so each entry is reset explicitly.
            for (int i = 0; i < SYNC_STAGES; i++) syncPipe[i] <= '0;
        end else begin
            syncPipe[0] <= gpioIn;
            for (int i = 1; i < SYNC_STAGES; i++) syncPipe[i] <= syncPipe[i-1];
        end
    end

    // While priming, snap tracks sync so the first real pin values after
    // reset are not mistaken for a change against the all-zero reset snap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap     <= '0;
            primeCnt <= CW'(SYNC_STAGES);
        end else if (primeCnt != '0) begin
            snap     <= syncVal;
            primeCnt <= primeCnt - CW'(1);
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rdIn[p] || wrCfg[p]) snap[8*p +: 8] <= syncVal[8*p +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intN       <= 1'b1;
            dataOutReg <= 8'h00;
        end else begin
            intN       <= ~|((syncVal ^ snap) & cfgReg);
            dataOutReg <= rdData;
        end
    end

endmodule

// File: tb/tb_gpio_expander_regs.sv
// Directed bench for gpio_expander_regs (NUM_PORTS=2, defaults): register map,
// polarity, interrupt set/clear/masking and asynchronous reset.
module tb_gpio_expander_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] gpioIn  = '0;
    logic [15:0] gpioOut;
    logic [15:0] gpioOe;
    logic        intN;
    int          vecCount = 0;
    int          errCount = 0;
    logic [7:0]  rd;

    gpio_expander_regs_if bus ();

    gpio_expander_regs #(.NUM_PORTS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .gpioIn  (gpioIn),
        .gpioOut (gpioOut),
        .gpioOe  (gpioOe),
        .intN    (intN)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
        bus.addr    = a;
        bus.dataIn  = d;
        bus.writeEn = 1'b1;
        step(1);
        bus.writeEn = 1'b0;
    endtask

    task automatic readReg(input logic [7:0] a, output logic [7:0] d);
        bus.addr = a;
        step(1);
        d = bus.dataOut;
    endtask

    task automatic pulseRead(input logic [7:0] a);
        bus.addr   = a;
        bus.readEn = 1'b1;
        step(1);
        bus.readEn = 1'b0;
    endtask

    initial begin
        logic [7:0] expTab [6];
        expTab = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        bus.addr    = '0;
        bus.dataIn  = '0;
        bus.writeEn = 1'b0;
        bus.readEn  = 1'b0;

        // 1. reset defaults
        step(3);
        rst = 1'b0;
        check("rst_dataOut", 16'(bus.dataOut), 16'h0000);
        check("rst_intN", 16'(intN), 16'h0001);
        check("rst_gpioOut", gpioOut, 16'hFFFF);
        check("rst_gpioOe", gpioOe, 16'h0000);
        step(3);
        for (int a = 2; a < 8; a++) begin
            readReg(8'(a), rd);
            check($sformatf("rst_read_%0d", a), 16'(rd), 16'(expTab[a-2]));
        end
        readReg(8'd8, rd);
        check("rst_read_8", 16'(rd), 16'h0000);
        check("idle_intN", 16'(intN), 16'h0001);

        // 2. write/read-back and direction
        writeReg(8'd3, 8'hA5);
        check("out1_gpioOut", 16'(gpioOut[15:8]), 16'h00A5);
        writeReg(8'd7, 8'h0F);
        check("cfg1_gpioOe", 16'(gpioOe[15:8]), 16'h00F0);
        readReg(8'd3, rd);
        check("out1_readback", 16'(rd), 16'h00A5);
        writeReg(8'd8, 8'h55);
        readReg(8'd2, rd);
        check("oob_write_ignored", 16'(rd), 16'h00FF);

        // 3. polarity inversion
        gpioIn[7:0] = 8'h3C;
        writeReg(8'd4, 8'hFF);
        step(2);
        check("pol_pin_intN", 16'(intN), 16'h0000);
        readReg(8'd0, rd);
        check("pol_in0", 16'(rd), 16'h00C3);
        gpioIn[7:0] = 8'h00;
        step(3);
        check("pol_selfclear", 16'(intN), 16'h0001);

        // 4. interrupt set, clear by read
        gpioIn[9] = 1'b1;
        step(2);
        check("int_not_yet", 16'(intN), 16'h0001);
        step(1);
        check("int_set_3cyc", 16'(intN), 16'h0000);
        pulseRead(8'd1);
        check("int_clear_1", 16'(intN), 16'h0000);
        check("int_read_data", 16'(bus.dataOut), 16'h0002);
        step(1);
        check("int_clear_2", 16'(intN), 16'h0001);

        // 5. self-clearing and masking
        gpioIn[0] = 1'b1;
        step(3);
        check("self_low", 16'(intN), 16'h0000);
        step(2);
        gpioIn[0] = 1'b0;
        step(3);
        check("self_high", 16'(intN), 16'h0001);
        writeReg(8'd6, 8'hFE);
        gpioIn[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("mask_hi_%0d", i), 16'(intN), 16'h0001);
        end
        gpioIn[0] = 1'b0;
        step(3);
        check("mask_lo", 16'(intN), 16'h0001);

        // 6. asynchronous reset mid-write, mid-interrupt
        gpioIn[8] = 1'b1;
        bus.addr = 8'd1;
        step(3);
        check("pre_rst_intN", 16'(intN), 16'h0000);
        check("pre_rst_dataOut", 16'(bus.dataOut), 16'h0003);
        bus.addr    = 8'd3;
        bus.dataIn  = 8'h12;
        bus.writeEn = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_intN", 16'(intN), 16'h0001);
        check("arst_gpioOut", gpioOut, 16'hFFFF);
        check("arst_dataOut", 16'(bus.dataOut), 16'h0000);
        check("arst_gpioOe", gpioOe, 16'h0000);
        bus.writeEn = 1'b0;
        gpioIn = '0;
        step(2);
        rst = 1'b0;
        step(3);
        readReg(8'd3, rd);
        check("post_rst_out1", 16'(rd), 16'h00FF);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/gpio_expander_regs.md
# gpio_expander_regs

Parametrised register file and pin logic for an I2C GPIO expander with NUM_PORTS 8-bit ports, sitting behind the i2cSlave core's addr/dataIn/writeEn/dataOut interface. It generalises the fixed two-port TCA9539 register interface:

- Input synchronisation.
- Polarity inversion.
- Per-pin direction control.
- A TCA9539-style open-drain interrupt that is cleared by reading the input port or by the pin returning to its captured state.

With NUM_PORTS=2 the register map is identical to the TCA9539.

## Interface
Parameters:
- NUM_PORTS, 2, number of 8-bit ports (1..8).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- OUT_RESET, 8'hFF, reset value of every output-port register.
- POL_RESET, 8'h00, reset value of every polarity register.
- CFG_RESET, 8'hFF, reset value of every config register (1 = input).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  8  register pointer from the i2cSlave core.
- dataIn  in  8  write data.
- writeEn  in  1  one-cycle write strobe.
- readEn  in  1  one-cycle pulse when the byte on dataOut for addr is taken for transmission.
- dataOut  out  8  registered read data.
- gpioIn  in  8*NUM_PORTS  raw pin inputs, asynchronous; port p occupies bits [8p+7:8p].
- gpioOut  out  8*NUM_PORTS  output-port register contents.
- gpioOe  out  8*NUM_PORTS  pin drive enable, = ~config.
- intN  out  1  registered active-low interrupt.

## Operation
Register map, for N = NUM_PORTS and p = 0..N-1:
- Input[p] at address p: read-only, value = sync[p] ^ pol[p].
- Output[p] at address N+p: read/write.
- Polarity[p] at address 2N+p: read/write.
- Config[p] at address 3N+p: read/write.
- Addresses ≥ 4N read 8'h00; writes to them are ignored.
- Writes to input addresses are ignored.

Read path:
- Every cycle, dataOut <= mux(addr).

Synchroniser:
- SYNC_STAGES flops per pin, all reset to 0.
- sync[p] is the last stage.

Snapshot:
- snap[p], 8 bits per port, reset to 0.
- Prime counter, reset to SYNC_STAGES, decrements to 0. While it is nonzero, snap follows sync every cycle, so no interrupt is raised from the reset value.
- readEn with addr==p loads snap[p] <= sync[p].
- writeEn to Config[p] also loads snap[p] <= sync[p], so a direction change never raises a spurious interrupt.

Interrupt:
- intN <= ~|( (sync ^ snap) & config ) over all ports.
- Only pins configured as inputs contribute.
- Polarity does not affect the interrupt.
- The interrupt clears automatically if a pin returns to its snapshot value.

Outputs:
- gpioOut = output registers, straight from flops.
- gpioOe = ~config registers.

Simultaneous events:
- writeEn and readEn in the same cycle both take effect.
- A readEn in the same cycle that sync changes captures the pre-edge sync value. The new value then differs from snap, so intN asserts on the following edge.

## Timing
Reset values:
- dataOut = 0.
- Output = OUT_RESET, Polarity = POL_RESET, Config = CFG_RESET; hence gpioOe = ~CFG_RESET, 0 by default.
- sync = 0, snap = 0.
- intN = 1.

Latencies:
- Write: register, gpioOut and gpioOe update on the edge where writeEn is sampled high (visible 1 cycle after the strobe).
- Read: dataOut is valid 1 cycle after addr is stable.
- Pin to interrupt: a gpioIn change reaches sync after SYNC_STAGES edges, and intN falls 1 edge later (SYNC_STAGES+1 cycles total).
- Interrupt clear: after readEn of the input port, intN rises 2 edges later (snap update, then intN register).

Reset mid-operation:
- rst asserted at any time returns all state to reset values immediately, without waiting for clk.
- intN goes high asynchronously.

## Test plan
All scenarios use NUM_PORTS=2 with default parameters.

1. Reset defaults.
   - Stimulus: after rst, read addresses 2..7.
   - Required: dataOut = FF, FF, 00, 00, FF, FF; gpioOe = 0; intN = 1; read of address 8 = 00.
2. Write/read-back and direction control.
   - Stimulus: write Output1(3)=A5, then Config1(7)=0F.
   - Required: gpioOut[15:8] = A5 one cycle after the first strobe; gpioOe[15:8] = F0 one cycle after the second; address 3 reads A5.
3. Polarity inversion.
   - Stimulus: gpioIn[7:0] = 3C, Polarity0(4) = FF.
   - Required: reading address 0 returns C3 once SYNC_STAGES has elapsed.
4. Interrupt set and clear by read.
   - Stimulus: from idle with gpioIn = 0, set gpioIn[9] = 1.
   - Required: intN = 0 exactly 3 cycles later.
   - Stimulus: readEn with addr = 1.
   - Required: intN = 1 two cycles later.
5. Self-clearing and masking.
   - Stimulus: toggle gpioIn[0] high for 5 cycles, then low.
   - Required: intN low, then high again without any read.
   - Stimulus: repeat the toggle with Config0 bit 0 = 0.
   - Required: intN stays 1.
6. Asynchronous reset.
   - Stimulus: rst asserted mid-write and mid-interrupt, between clk edges.
   - Required: intN = 1, gpioOut = FFFF, dataOut = 00 immediately, without waiting for clk.
